// File: rtl/fib_pkg.sv
// Shared types, constants and the round-robin pick helper for the fib_sched scheduler.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int FIB_N_W  = 4;
  localparam int FIB_W    = 32;
  localparam int MAX_NREQ = 16;
  localparam int PICK_W   = 4;

  // First set bit strictly after ptr, wrapping modulo nreq; returns ptr when nothing is set.
  function automatic logic [PICK_W-1:0] rr_pick(input logic [MAX_NREQ-1:0] req_vec,
                                                input logic [PICK_W-1:0]   ptr,
                                                input int                  nreq);
    logic              found;
    logic [PICK_W-1:0] k;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 1; i <= MAX_NREQ; i++) begin
      k = PICK_W'((int'(ptr) + i) % nreq);
      if (!found && (i <= nreq) && req_vec[k]) begin
        rr_pick = k;
        found   = 1'b1;
      end else begin
        found = found;
      end
    end
  endfunction

endpackage

// File: rtl/fib_sched_if.sv
// Request/response bundle between the requesters, the result consumer and fib_sched.
interface fib_sched_if #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_n;
  logic [W-1:0]      seed_a;
  logic [W-1:0]      seed_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_data;
  logic              rsp_ovf;
  logic              busy;

  modport master (
    output req_valid, req_n, seed_a, seed_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_ovf, busy
  );

  modport slave (
    input  req_valid, req_n, seed_a, seed_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_ovf, busy
  );
endinterface

// File: rtl/fib_engine.sv
// Iterative seeded-Fibonacci datapath: one addition per step, sticky carry within a job.
module fib_engine
  import fib_pkg::*;
#(
  parameter int W = FIB_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [W-1:0]       seed_a,
  input  logic [W-1:0]       seed_b,
  input  logic [FIB_N_W-1:0] n,
  output logic [W-1:0]       f,
  output logic               ovf,
  output logic               last
);

  logic [W-1:0]       f_r;
  logic [W-1:0]       c_r;
  logic [FIB_N_W-1:0] cnt_r;
  logic [FIB_N_W-1:0] n_q_r;
  logic               ovf_r;
  logic [W:0]         load_sum_s;
  logic [W:0]         step_sum_s;

  assign load_sum_s = {1'b0, seed_a} + {1'b0, seed_b};
  assign step_sum_s = {1'b0, c_r} + {1'b0, f_r};

  // Load clears the carry history so the overflow flag never leaks between jobs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_r   <= '0;
      c_r   <= '0;
      cnt_r <= '0;
      n_q_r <= '0;
      ovf_r <= 1'b0;
    end else if (load) begin
      f_r   <= load_sum_s[W-1:0];
      c_r   <= seed_b;
      cnt_r <= '0;
      n_q_r <= n;
      ovf_r <= load_sum_s[W];
    end else if (step) begin
      f_r   <= step_sum_s[W-1:0];
      c_r   <= f_r;
      cnt_r <= cnt_r + FIB_N_W'(1);
      ovf_r <= ovf_r | step_sum_s[W];
    end else begin
      f_r   <= f_r;
      c_r   <= c_r;
      cnt_r <= cnt_r;
      n_q_r <= n_q_r;
      ovf_r <= ovf_r;
    end
  end

  assign f    = f_r;
  assign ovf  = ovf_r;
  assign last = (cnt_r == n_q_r);

endmodule

// File: rtl/fib_sched.sv
// Round-robin scheduler sharing one Fibonacci engine among NREQ requesters, one job in flight.
module fib_sched
  import fib_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = FIB_W,
  parameter int IDW  = 2
) (
  input logic        clk,
  input logic        reset,
  fib_sched_if.slave bus
);

  state_t             state_r;
  logic [IDW-1:0]     rr_ptr_r;
  logic [IDW-1:0]     id_q_r;
  logic               rsp_valid_r;
  logic [W-1:0]       rsp_data_r;
  logic [IDW-1:0]     rsp_id_r;
  logic               rsp_ovf_r;
  logic               busy_r;

  logic [MAX_NREQ-1:0] req_vec_s;
  logic [PICK_W-1:0]   pick_s;
  logic                any_req_s;
  logic                accept_s;
  logic [IDW-1:0]      grant_s;
  logic [FIB_N_W-1:0]  n_sel_s;
  logic [NREQ-1:0]     req_ready_s;
  logic                step_s;
  logic [W-1:0]        eng_f_s;
  logic                eng_ovf_s;
  logic                eng_last_s;

  assign req_vec_s = MAX_NREQ'(bus.req_valid);
  assign pick_s    = rr_pick(req_vec_s, PICK_W'(rr_ptr_r), NREQ);
  assign any_req_s = |bus.req_valid;
  // Gated by reset so no requester sees an accept while the block is held.
  assign accept_s  = (state_r == IDLE) && any_req_s && !reset;
  assign step_s    = (state_r == RUN) && !eng_last_s;

  // Decode the winner into its id, its iteration count and the one-hot ready.
  always_comb begin
    grant_s     = '0;
    n_sel_s     = '0;
    req_ready_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_s == PICK_W'(i)) begin
        grant_s        = IDW'(i);
        n_sel_s        = bus.req_n[FIB_N_W*i +: FIB_N_W];
        req_ready_s[i] = accept_s;
      end else begin
        req_ready_s[i] = 1'b0;
      end
    end
  end

  fib_engine #(.W(W)) u_engine (
    .clk    (clk),
    .reset  (reset),
    .load   (accept_s),
    .step   (step_s),
    .seed_a (bus.seed_a),
    .seed_b (bus.seed_b),
    .n      (n_sel_s),
    .f      (eng_f_s),
    .ovf    (eng_ovf_s),
    .last   (eng_last_s)
  );

  // Control FSM with registered response, id and busy outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      rr_ptr_r    <= IDW'(NREQ - 1);
      id_q_r      <= '0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= '0;
      rsp_id_r    <= '0;
      rsp_ovf_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            id_q_r   <= grant_s;
            rr_ptr_r <= grant_s;
            busy_r   <= 1'b1;
            state_r  <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (eng_last_s) begin
            rsp_data_r  <= eng_f_s;
            rsp_id_r    <= id_q_r;
            rsp_ovf_r   <= eng_ovf_s;
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
          end else begin
            state_r <= RUN;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_ovf   = rsp_ovf_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_fib_sched.sv
// Self-checking bench for fib_sched: vector table, corner-case sequences and randomized traffic.
module tb_fib_sched;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int IDW  = 2;

  logic       clk;
  logic       reset;
  logic [3:0] rn [NREQ];
  int         checks = 0;
  int         errors = 0;
  int         rr_last = NREQ - 1;

  fib_sched_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

  fib_sched #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.req_n = {rn[3], rn[2], rn[1], rn[0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Sequence x0=a, x1=b, x(k+2)=x(k)+x(k+1); job result is x(n+2) mod 2^32.
  function automatic void fib_ref(input logic [31:0] a, input logic [31:0] b, input int n,
                                  output logic [31:0] r, output logic o);
    longint unsigned x, y, s;
    x = 64'(a);
    y = 64'(b);
    o = 1'b0;
    for (int k = 0; k <= n; k++) begin
      s = x + y;
      if (s >= 64'h1_0000_0000) o = 1'b1;
      x = y;
      y = s & 64'hFFFF_FFFF;
    end
    r = y[31:0];
  endfunction

  function automatic int exp_winner(input logic [NREQ-1:0] pend);
    int k;
    for (int i = 1; i <= NREQ; i++) begin
      k = (rr_last + i) % NREQ;
      if (pend[k]) return k;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int g);
    g = -1;
    for (int t = 0; t < 200 && g < 0; t++) begin
      #1;
      if (bus.req_ready != '0) begin
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) g = i;
      end else begin
        @(posedge clk);
      end
    end
    if (g < 0) chk("grant_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (bus.busy && t < 200) begin tick(); t++; end
    chk(name, bus.busy, 1'b0);
  endtask

  task automatic serve_pending(input string name);
    int g, e;
    bus.rsp_ready = 1'b1;
    for (int j = 0; j < 3 * NREQ && bus.req_valid != '0; j++) begin
      e = exp_winner(bus.req_valid);
      wait_grant(g);
      chk(name, g, e);
      if (g >= 0) begin
        tick();
        bus.req_valid[2'(g)] = 1'b0;
        rr_last = g;
      end
    end
    wait_idle({name, "_idle"});
    bus.rsp_ready = 1'b0;
  endtask

  task automatic run_job(input string name, input int id, input logic [31:0] a, input logic [31:0] b,
                         input int n, input logic [31:0] exp_d, input logic exp_o);
    int g, lat;
    bus.seed_a = a;
    bus.seed_b = b;
    rn[id] = 4'(n);
    bus.req_valid[2'(id)] = 1'b1;
    wait_grant(g);
    chk({name, "_grant"}, g, id);
    chk({name, "_ready_onehot"}, bus.req_ready, 4'b0001 << id);
    if (g >= 0) begin
      tick();
      bus.req_valid[2'(id)] = 1'b0;
      rr_last = id;
      bus.seed_a = $urandom;
      bus.seed_b = $urandom;
      lat = 0;
      while (!bus.rsp_valid && lat < 40) begin tick(); lat++; end
      chk({name, "_latency"}, lat, n + 1);
      chk({name, "_data"}, bus.rsp_data, exp_d);
      chk({name, "_id"}, bus.rsp_id, id);
      chk({name, "_ovf"}, bus.rsp_ovf, exp_o);
      chk({name, "_busy_resp"}, bus.busy, 1'b1);
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      chk({name, "_valid_drop"}, bus.rsp_valid, 1'b0);
      chk({name, "_busy_idle"}, bus.busy, 1'b0);
    end else begin
      bus.req_valid[2'(id)] = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    rr_last = NREQ - 1;
  endtask

  // A requester may only drop req_valid after it has seen req_ready.
  logic [NREQ-1:0] mon_valid_q = '0;
  logic [NREQ-1:0] mon_ready_q = '0;
  always @(negedge clk) begin
    if (!reset) chk("withdraw", |(mon_valid_q & ~mon_ready_q & ~bus.req_valid), 1'b0);
    mon_valid_q <= reset ? '0 : bus.req_valid;
    mon_ready_q <= bus.req_ready;
  end

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    int          n;
    logic [31:0] d;
    logic        o;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] d;
    logic        o;
  } exp_t;

  vec_t tbl [8];
  exp_t q [$];

  initial begin
    int g, e, cnt, nrsp, lat;
    logic [31:0] rd;
    logic ro;
    exp_t x;
    logic prev_hold;
    logic [31:0] prev_data;
    logic [1:0] prev_id;
    logic [NREQ-1:0] clr;

    tbl[0] = '{0, 32'd0,          32'd1,          5,  32'd13,         1'b0};
    tbl[1] = '{1, 32'd3,          32'd4,          0,  32'd7,          1'b0};
    tbl[2] = '{1, 32'd3,          32'd4,          2,  32'd18,         1'b0};
    tbl[3] = '{2, 32'hFFFF_FFFF,  32'd1,          0,  32'd0,          1'b1};
    tbl[4] = '{2, 32'd0,          32'd1,          3,  32'd5,          1'b0};
    tbl[5] = '{3, 32'd0,          32'd1,          15, 32'd1597,       1'b0};
    tbl[6] = '{0, 32'h8000_0000,  32'h8000_0000,  1,  32'h8000_0000,  1'b1};
    tbl[7] = '{3, 32'h9000_0000,  32'h1000_0000,  2,  32'h5000_0000,  1'b1};

    reset = 1'b0;
    bus.req_valid = '0;
    bus.seed_a = '0;
    bus.seed_b = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) rn[i] = 4'd0;
    #2;
    reset = 1'b1;
    repeat (2) tick();
    bus.req_valid = 4'b1111;
    #1;
    chk("reset_req_ready", bus.req_ready, 4'b0000);
    chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
    chk("reset_rsp_data", bus.rsp_data, 32'd0);
    chk("reset_rsp_id", bus.rsp_id, 2'd0);
    chk("reset_rsp_ovf", bus.rsp_ovf, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);
    bus.req_valid = '0;
    tick();
    reset = 1'b0;
    rr_last = NREQ - 1;

    for (int v = 0; v < 8; v++)
      run_job($sformatf("vec%0d", v), tbl[v].id, tbl[v].a, tbl[v].b, tbl[v].n, tbl[v].d, tbl[v].o);

    // Fairness: three requesters held high, consumer always ready.
    do_reset();
    bus.seed_a = 32'd0;
    bus.seed_b = 32'd1;
    for (int i = 0; i < NREQ; i++) rn[i] = 4'd0;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0111;
    for (int k = 0; k < 5; k++) begin
      e = exp_winner(bus.req_valid);
      wait_grant(g);
      chk($sformatf("fair_grant%0d", k), g, e);
      if (g >= 0) rr_last = g;
      tick();
    end
    serve_pending("fair_drain");

    // Backpressure: result held while other requesters wait.
    bus.seed_a = 32'd0;
    bus.seed_b = 32'd1;
    rn[1] = 4'd1;
    bus.req_valid[1] = 1'b1;
    wait_grant(g);
    chk("bp_grant", g, 1);
    tick();
    bus.req_valid[1] = 1'b0;
    rr_last = 1;
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin tick(); lat++; end
    rn[0] = 4'd0;
    rn[3] = 4'd0;
    bus.req_valid[0] = 1'b1;
    bus.req_valid[3] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.seed_a = $urandom;
      #1;
      chk("bp_valid", bus.rsp_valid, 1'b1);
      chk("bp_data", bus.rsp_data, 32'd2);
      chk("bp_id", bus.rsp_id, 2'd1);
      chk("bp_req_ready", bus.req_ready, 4'b0000);
      chk("bp_busy", bus.busy, 1'b1);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    #1;
    chk("bp_valid_drop", bus.rsp_valid, 1'b0);
    chk("bp_next_accept", bus.req_ready, 4'b0001 << exp_winner(bus.req_valid));
    serve_pending("bp_drain");

    // Reset three cycles into a long RUN.
    bus.seed_a = 32'd0;
    bus.seed_b = 32'd1;
    rn[2] = 4'd10;
    bus.req_valid[2] = 1'b1;
    wait_grant(g);
    tick();
    bus.req_valid[2] = 1'b0;
    repeat (3) tick();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_run_busy", bus.busy, 1'b0);
    chk("rst_run_valid", bus.rsp_valid, 1'b0);
    tick();
    reset = 1'b0;

    // Reset while a response is waiting for the consumer.
    rn[1] = 4'd0;
    bus.req_valid[1] = 1'b1;
    wait_grant(g);
    tick();
    bus.req_valid[1] = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin tick(); lat++; end
    chk("rst_resp_pre_valid", bus.rsp_valid, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_resp_valid", bus.rsp_valid, 1'b0);
    chk("rst_resp_busy", bus.busy, 1'b0);
    tick();
    reset = 1'b0;
    rr_last = NREQ - 1;
    bus.rsp_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.rsp_valid) cnt++;
      tick();
    end
    chk("rst_no_rsp", cnt, 0);
    bus.req_valid = 4'b1011;
    wait_grant(g);
    chk("rst_first_winner", g, 0);
    if (g >= 0) begin
      tick();
      bus.req_valid[0] = 1'b0;
      rr_last = 0;
    end
    serve_pending("rst_drain");

    // Randomized traffic against the reference model.
    nrsp = 0;
    prev_hold = 1'b0;
    prev_data = '0;
    prev_id = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.seed_a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 255))) : $urandom;
      bus.seed_b = $urandom;
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] && cyc < 2600 && $urandom_range(0, 3) == 0) begin
          rn[i] = 4'($urandom_range(0, 15));
          bus.req_valid[2'(i)] = 1'b1;
        end
      end
      bus.rsp_ready = (cyc >= 2600) ? 1'b1 : ($urandom_range(0, 2) != 0);
      #1;
      if (prev_hold) begin
        chk("rand_hold_valid", bus.rsp_valid, 1'b1);
        chk("rand_hold_data", bus.rsp_data, prev_data);
        chk("rand_hold_id", bus.rsp_id, prev_id);
      end
      clr = '0;
      if (bus.req_ready != '0) begin
        e = exp_winner(bus.req_valid);
        chk("rand_grant", bus.req_ready, 4'b0001 << e);
        fib_ref(bus.seed_a, bus.seed_b, int'(rn[e]), rd, ro);
        q.push_back('{e, rd, ro});
        rr_last = e;
        clr = bus.req_ready;
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (q.size() == 0) begin
          chk("rand_unexpected_rsp", 64'd1, 64'd0);
        end else begin
          x = q.pop_front();
          chk("rand_id", bus.rsp_id, x.id);
          chk("rand_data", bus.rsp_data, x.d);
          chk("rand_ovf", bus.rsp_ovf, x.o);
          nrsp++;
        end
      end
      prev_hold = bus.rsp_valid && !bus.rsp_ready;
      prev_data = bus.rsp_data;
      prev_id = bus.rsp_id;
      @(posedge clk);
      #1;
      bus.req_valid = bus.req_valid & ~clr;
    end
    chk("rand_queue_empty", q.size(), 0);
    chk("rand_enough_rsp", (nrsp > 50), 1'b1);
    chk("rand_final_idle", bus.busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fib_sched.md
Name: fib_sched

Overview:
- Shares one iterative Fibonacci engine among NREQ requesters.
- Round-robin arbitration; one job in flight at a time.
- Each job computes the seeded recurrence over n steps, one addition per cycle, and returns the result tagged with the requester id.
- Sits between the control-plane requesters and the downstream result consumer.

Parameters:
- NREQ, 4, number of requesters (2..16).
- W, 32, data width of seeds and result.
- IDW, 2, width of rsp_id; must equal clog2(NREQ).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request.
- req_ready  out  NREQ  one-hot accept to the granted requester.
- req_n  in  4*NREQ  iteration count per requester; slice i = [4i+3:4i].
- seed_a  in  W  first seed, sampled at accept.
- seed_b  in  W  second seed, sampled at accept.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_data  out  W  result.
- rsp_ovf  out  1  at least one addition in this job carried out of W bits.
- busy  out  1  high in RUN and RESP.

Behaviour:
- Reset values: state=IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_ovf=0, busy=0, rr_ptr=NREQ-1. req_ready is 0 during reset.
- Reset is asynchronous: asserting it mid-RUN or mid-RESP aborts the job and drops rsp_valid immediately. No response is issued for the aborted job.
- FSM has three states: IDLE, RUN, RESP.
- IDLE:
  - If any req_valid is high, select the winner g as the first set bit searching from rr_ptr+1 upward, wrapping modulo NREQ.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - At the accept edge: f<=seed_a+seed_b, c<=seed_b, cnt<=0, n_q<=req_n[g], id_q<=g, ovf<=carry of that add, rr_ptr<=g, state<=RUN.
- RUN:
  - If cnt==n_q, state<=RESP: rsp_data<=f, rsp_id<=id_q, rsp_ovf<=ovf, rsp_valid<=1.
  - Otherwise: f<=c+f, c<=f, cnt<=cnt+1, ovf<=ovf|carry.
- RESP:
  - rsp_valid, rsp_data, rsp_id and rsp_ovf are held stable until rsp_valid&rsp_ready.
  - On that handshake: rsp_valid<=0, state<=IDLE.
  - req_ready stays 0 in RESP.
- Latency: rsp_valid rises n+1 cycles after the accept edge.
  - Next accept is no earlier than the cycle after the response handshake, so back-to-back jobs have a one-cycle IDLE bubble.
- Arithmetic: all additions are modulo 2^W. Carry-out is taken from a W+1-bit sum.
- Result convention: for seeds (0,1), n maps to 0→1, 1→2, 2→3, 3→5, 5→13. n=15 is the maximum.
- Requester rules:
  - A requester holds req_valid and req_n stable until it sees req_ready.
  - Withdrawal before accept is illegal; the bench flags it.
  - req_valid from a requester that is not granted is ignored and stays pending.
- Seeds are sampled only at the accept edge. Seed changes during RUN/RESP have no effect on the job in flight.
- busy=1 in RUN and RESP, 0 in IDLE.

Decomposition:
- Package fib_pkg holds:
  - state enum {IDLE, RUN, RESP};
  - FIB_N_W=4 and default W=32;
  - a function rr_pick(req_vec, ptr) returning the winner index.
- Sub-module fib_engine holds f, c, cnt, n_q and ovf.
  - Inputs: load, step, seed_a, seed_b, n.
  - Outputs: f, ovf, last (cnt==n_q).
- The FSM, arbiter, and response and id registers stay in fib_sched.

Test Plan:
- Single request: requester 0 with seeds 0/1, n=5 → accept, rsp_valid 6 cycles later, rsp_data=13, rsp_id=0, rsp_ovf=0.
- n=0, seeds 3/4 → rsp_data=7 one cycle after accept; then n=2, seeds 3/4 → rsp_data=18.
- Fairness: requesters 0, 1 and 2 hold req_valid continuously, rsp_ready=1 → grant order 0,1,2,0,1. No requester is granted twice before the others are served.
- Overflow: W=32, seeds 0xFFFFFFFF/1, n=0 → rsp_data=0, rsp_ovf=1. The next job with seeds 0/1, n=3 returns 5 with rsp_ovf=0 (the flag is not sticky across jobs).
- Backpressure: rsp_ready held low 5 cycles in RESP → rsp_data, rsp_id and rsp_valid stable; req_ready stays 0 despite other req_valid high; the accept occurs the cycle after the handshake.
- Reset mid-job: reset asserted 3 cycles into RUN with n=10 → rsp_valid=0 and busy=0 immediately, no response for that job. After release, requester 0 wins first (rr_ptr restored to NREQ-1).
